muldiv_sequencer: RTL and testbench

- Multi-cycle controller that runs MIPS-style unsigned MULTU and DIVU by sequencing the shared 32-bit ALU for 32 iterations.
- The ALU performs the per-step add or subtract.
- Results land in HI/LO registers for a later MFHI/MFLO.
- Sits beside the ALU in the execute stage. It owns the ALU input and control muxes only while busy.

---
 rtl/muldiv_sequencer.sv | 179 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Runs unsigned MULTU / DIVU by borrowing the execute-stage ALU for 32
// iterations. It uses shift-and-add for multiply and restoring shift-subtract
// for divide. Results land in HI/LO and stay there until the next accepted
// start or reset.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start, op               request (0=MULTU, 1=DIVU); sampled in IDLE/DONE only
//   operand_a, operand_b    multiplicand/dividend, multiplier/divisor
//   busy                    high while iterating
//   done                    one-cycle completion pulse
//   err_div_zero            last DIVU had a zero divisor
//   hi, lo                  product[63:32]/remainder, product[31:0]/quotient
//   alu_input_a/b, alu_control  drive the shared ALU (neutral when not busy)
//   alu_result, alu_cout    ALU outputs, consumed only while iterating
//
// Handshake: a request is taken on any rising edge where start=1 and the
// sequencer is in IDLE or DONE. There is no back-pressure. The requester
// watches busy/done, and start is ignored while busy.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int                     WORD_SIZE            = 32,
  parameter int                     CONTROL_SIGNAL_SIZE  = 4,
  parameter logic [CONTROL_SIGNAL_SIZE-1:0] CONTROL_AND          = 4'h0,
  parameter logic [CONTROL_SIGNAL_SIZE-1:0] CONTROL_ADD_UNSIGNED = 4'h3,
  parameter logic [CONTROL_SIGNAL_SIZE-1:0] CONTROL_SUB          = 4'h6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           op,
  input  logic [WORD_SIZE-1:0]           operand_a,
  input  logic [WORD_SIZE-1:0]           operand_b,
  output logic                           busy,
  output logic                           done,
  output logic                           err_div_zero,
  output logic [WORD_SIZE-1:0]           hi,
  output logic [WORD_SIZE-1:0]           lo,
  output logic [WORD_SIZE-1:0]           alu_input_a,
  output logic [WORD_SIZE-1:0]           alu_input_b,
  output logic [CONTROL_SIGNAL_SIZE-1:0] alu_control,
  input  logic [WORD_SIZE-1:0]           alu_result,
  input  logic                           alu_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WORD_SIZE - 1);

  state_t               state;
  logic [5:0]           step;
  // Multiplicand (MUL) or divisor (DIV), captured at acceptance.
  logic [WORD_SIZE-1:0] operand_reg;

  // Divide: partial remainder shifted left by one, taking the next dividend bit.
  logic [WORD_SIZE-1:0] div_shift;
  // The subtract succeeds when the shifted-out bit makes the true 33-bit
  // remainder exceed any 32-bit divisor, or when the ALU reports no borrow.
  logic                 div_take;
  logic                 last_step;
  logic                 can_accept;

  assign div_shift  = {hi[WORD_SIZE-2:0], lo[WORD_SIZE-1]};
  assign div_take   = hi[WORD_SIZE-1] | ~alu_cout;
  assign last_step  = (step == LAST_STEP);
  assign can_accept = start && ((state == IDLE) || (state == DONE));

  // ALU steering. It is neutral outside MUL/DIV so the execute-stage mux
  // sees a quiet AND of zeros.
  always_comb begin
    alu_input_a = '0;
    alu_input_b = '0;
    alu_control = CONTROL_AND;
    case (state)
      MUL: begin
        alu_input_a = hi;
        alu_input_b = operand_reg;
        alu_control = CONTROL_ADD_UNSIGNED;
      end
      DIV: begin
        alu_input_a = div_shift;
        alu_input_b = operand_reg;
        alu_control = CONTROL_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_div_zero <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      step         <= '0;
      operand_reg  <= '0;
    end else begin
      case (state)
        MUL: begin
          step <= step + 6'd1;
          // Shift-and-add: the add's carry becomes the new top bit of HI.
          if (lo[0]) begin
            hi <= {alu_cout, alu_result[WORD_SIZE-1:1]};
            lo <= {alu_result[0], lo[WORD_SIZE-1:1]};
          end else begin
            hi <= {1'b0, hi[WORD_SIZE-1:1]};
            lo <= {hi[0], lo[WORD_SIZE-1:1]};
          end
          if (last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DIV: begin
          step <= step + 6'd1;
          if (div_take) begin
            hi <= alu_result;
            lo <= {lo[WORD_SIZE-2:0], 1'b1};
          end else begin
            hi <= div_shift;
            lo <= {lo[WORD_SIZE-2:0], 1'b0};
          end
          if (last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          // IDLE and DONE behave alike. DONE only differs in that done is
          // high during it, and it falls back to IDLE after one cycle.
          done <= 1'b0;
          if (can_accept) begin
            err_div_zero <= 1'b0;
            step         <= '0;
            if (!op) begin
              hi          <= '0;
              lo          <= operand_b;
              operand_reg <= operand_a;
              state       <= MUL;
              busy        <= 1'b1;
            end else if (operand_b == '0) begin
              // Divide by zero skips iteration entirely.
              hi           <= operand_a;
              lo           <= '1;
              operand_reg  <= operand_b;
              err_div_zero <= 1'b1;
              state        <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              hi          <= '0;
              lo          <= operand_a;
              operand_reg <= operand_b;
              state       <= DIV;
              busy        <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Bench for muldiv_sequencer. A behavioural ALU closes the loop. A table of
// operations carries expected HI/LO/err and done latency. Expected results go
// into a queue at issue time and are popped when done pulses. Hand-written
// sequences cover start during an operation, back-to-back start in DONE, and
// reset mid-divide.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, op;
  logic [W-1:0]  operand_a, operand_b;
  logic          busy, done, err_div_zero;
  logic [W-1:0]  hi, lo;
  logic [W-1:0]  alu_input_a, alu_input_b, alu_result;
  logic [3:0]    alu_control;
  logic          alu_cout;

  muldiv_sequencer dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .err_div_zero (err_div_zero),
    .hi           (hi),
    .lo           (lo),
    .alu_input_a  (alu_input_a),
    .alu_input_b  (alu_input_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout)
  );

  // Behavioural ALU. For SUB, cout reports a borrow (a < b).
  always_comb begin
    case (alu_control)
      4'h3:    {alu_cout, alu_result} = {1'b0, alu_input_a} + {1'b0, alu_input_b};
      4'h6:    {alu_cout, alu_result} = {1'b0, alu_input_a} - {1'b0, alu_input_b};
      default: {alu_cout, alu_result} = {1'b0, alu_input_a & alu_input_b};
    endcase
  end

  // scoreboard: {err, hi, lo}
  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_exp;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive a request; it is accepted on the next rising edge. Returns #1 after
  // that edge, i.e. in cycle k=0.
  task automatic start_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic err, input logic [W-1:0] h, input logic [W-1:0] l);
    exp_q.push_back({err, h, l});
  endtask

  // Watch from cycle k=0 until done, checking latency, busy length and the
  // result. If disturb_at >= 0, a junk start is pulsed in that cycle.
  // Returns in the done cycle.
  task automatic wait_done(input int exp_lat, input int disturb_at);
    int k = 0;
    int busy_cnt = 0;
    logic [2*W:0] e;
    while (1) begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) busy_cnt++;
      if (done) break;
      if (k >= 40) begin
        check("done_timeout", 0, 1);
        break;
      end
      if (k == disturb_at) begin
        start     = 1'b1;
        op        = ~op;
        operand_a = $urandom;
        operand_b = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
    end
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cnt), (exp_lat == 0) ? 64'd0 : 64'd32);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check("hi",  64'(hi), 64'(e[2*W-1:W]));
      check("lo",  64'(lo), 64'(e[W-1:0]));
      check("err", 64'(err_div_zero), 64'(e[2*W]));
    end
  endtask

  // Stimulus table
  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
    int           lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    logic [63:0]  prod;
    logic [W-1:0] ra, rb;
    int           done_seen;

    reset     = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err",  64'(err_div_zero), 0);
    check("rst_hi",   64'(hi), 0);
    check("rst_lo",   64'(lo), 0);
    check("rst_alu_ctl", 64'(alu_control), 0);
    check("rst_alu_a", 64'(alu_input_a), 0);
    check("rst_alu_b", 64'(alu_input_b), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0, 32};
    vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0, 32};
    vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 32};
    vecs[3] = '{1'b1, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF,   32'd1,          1'b0, 32};
    vecs[4] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1'b1, 0};
    vecs[5] = '{1'b0, 32'd3,          32'd3,          32'd0,          32'd9,          1'b0, 32};
    // Random operands with results from a 64-bit reference.
    for (int i = 6; i < NV; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'hFFFF) << $urandom_range(0, 16);
      if (rb == '0) rb = 32'd1;
      vecs[i].op  = i[0];
      vecs[i].a   = ra;
      vecs[i].b   = rb;
      vecs[i].err = 1'b0;
      vecs[i].lat = 32;
      if (!i[0]) begin
        prod        = {32'd0, ra} * {32'd0, rb};
        vecs[i].hi  = prod[63:32];
        vecs[i].lo  = prod[31:0];
      end else begin
        vecs[i].hi  = ra % rb;
        vecs[i].lo  = ra / rb;
      end
    end

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      push_exp(vecs[i].err, vecs[i].hi, vecs[i].lo);
      wait_done(vecs[i].lat, -1);
      // One idle cycle: done must drop and results must hold.
      @(posedge clk);
      #1;
      check("done_pulse_len", 64'(done), 0);
      check("hold_hi", 64'(hi), 64'(last_exp[2*W-1:W]));
      check("hold_lo", 64'(lo), 64'(last_exp[W-1:0]));
      check("hold_err", 64'(err_div_zero), 64'(last_exp[2*W]));
    end

    // Start during MUL is ignored. A start in the DONE cycle is accepted
    // back-to-back.
    start_op(1'b0, 32'd7, 32'd6);
    push_exp(1'b0, 32'd0, 32'd42);
    wait_done(32, 10);
    start_op(1'b0, 32'd3, 32'd3);
    push_exp(1'b0, 32'd0, 32'd9);
    wait_done(32, -1);
    @(posedge clk);
    #1;

    // Reset mid-divide aborts with no done pulse.
    start_op(1'b1, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_hi",   64'(hi), 0);
    check("abort_lo",   64'(lo), 0);
    done_seen = 0;
    repeat (40) begin
      if (done || busy) done_seen++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 64'(done_seen), 0);
    start_op(1'b1, 32'd100, 32'd7);
    push_exp(1'b0, 32'd2, 32'd14);
    wait_done(32, -1);

    check("sb_drained", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
